// File: rtl/fmq_cmd_tx.sv
// Host-side command engine: encodes one command into a 3-byte frame, sends it byte by byte
// waiting for each echo, then optionally captures a reply. Define FMQ_CMD_ECHO_CHECK_EN to compare echoes.
module fmq_cmd_tx #(
  parameter int unsigned TIMEOUT  = 50000,
  parameter int unsigned TO_WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [2:0]  i_cmd_op,
  input  logic [18:0] i_cmd_arg,
  output logic [7:0]  o_tx_tdata,
  output logic        o_tx_tvalid,
  input  logic        i_tx_tready,
  input  logic [7:0]  i_rx_tdata,
  input  logic        i_rx_tvalid,
  output logic        o_rx_tready,
  output logic        o_rsp_valid,
  output logic [7:0]  o_rsp_data,
  output logic [1:0]  o_rsp_err
);

  typedef enum logic [2:0] {StIdle, StSend, StEcho, StReply, StDone} state_e;

  localparam logic [1:0] ErrOk       = 2'd0;
  localparam logic [1:0] ErrTimeout  = 2'd1;
  localparam logic [1:0] ErrMismatch = 2'd2;
  localparam logic [1:0] ErrBadOp    = 2'd3;
  localparam logic [TO_WIDTH-1:0] ToLast = TO_WIDTH'(TIMEOUT - 1);

  state_e              r_state;
  logic [7:0]          r_tx_tdata;
  logic                r_tx_tvalid;
  logic                r_rx_tready;
  logic                r_rsp_valid;
  logic [7:0]          r_rsp_data;
  logic [1:0]          r_rsp_err;
  logic [7:0]          r_b1;
  logic [7:0]          r_b2;
  logic                r_reply;
  logic [1:0]          r_idx;
  logic                r_mismatch;
  logic [TO_WIDTH-1:0] r_cnt;

  logic [1:0] w_op2;
  logic [4:0] w_f;
  logic [6:0] w_g;
  logic [6:0] w_h;
  logic       w_op_ok;
  logic       w_has_reply;
  logic       w_tx_hs;
  logic       w_rx_hs;
  logic       w_to;
  logic       w_echo_bad;
  logic       w_mismatch;

  always_comb begin
    w_op2       = 2'b11;
    w_f         = 5'd0;
    w_g         = 7'd0;
    w_h         = 7'd0;
    w_op_ok     = 1'b1;
    w_has_reply = 1'b0;
    case (i_cmd_op)
      3'd0: begin
        w_op2 = 2'b00;
        w_f   = i_cmd_arg[18:14];
        w_g   = i_cmd_arg[13:7];
        w_h   = i_cmd_arg[6:0];
      end
      3'd1: begin
        w_op2 = 2'b01;
        w_f   = i_cmd_arg[18:14];
        w_g   = i_cmd_arg[13:7];
        w_h   = i_cmd_arg[6:0];
      end
      3'd2: begin
        w_op2       = 2'b10;
        w_has_reply = 1'b1;
      end
      3'd3: begin
        w_g = {5'd0, i_cmd_arg[8:7]};
        w_h = i_cmd_arg[6:0];
      end
      3'd4: w_f = 5'b10000;
      3'd5: begin
        w_f         = 5'b01000;
        w_has_reply = 1'b1;
      end
      default: w_op_ok = 1'b0;
    endcase
  end

  assign w_tx_hs = r_tx_tvalid & i_tx_tready;
  assign w_rx_hs = r_rx_tready & i_rx_tvalid;
  assign w_to    = (r_cnt == ToLast);

`ifdef FMQ_CMD_ECHO_CHECK_EN
  assign w_echo_bad = (i_rx_tdata != r_tx_tdata);
`else
  assign w_echo_bad = 1'b0;
`endif
  assign w_mismatch = r_mismatch | w_echo_bad;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= StIdle;
      r_tx_tdata  <= 8'h00;
      r_tx_tvalid <= 1'b0;
      r_rx_tready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 8'h00;
      r_rsp_err   <= ErrOk;
      r_b1        <= 8'h00;
      r_b2        <= 8'h00;
      r_reply     <= 1'b0;
      r_idx       <= 2'd0;
      r_mismatch  <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        StIdle: begin
          if (i_cmd_valid) begin
            r_idx       <= 2'd0;
            r_mismatch  <= 1'b0;
            r_cnt       <= '0;
            r_rx_tready <= 1'b0;
            if (w_op_ok) begin
              r_state     <= StSend;
              r_tx_tdata  <= {1'b1, w_op2, w_f};
              r_b1        <= {1'b0, w_g};
              r_b2        <= {1'b0, w_h};
              r_reply     <= w_has_reply;
              r_tx_tvalid <= 1'b1;
            end else begin
              r_state     <= StDone;
              r_rsp_valid <= 1'b1;
              r_rsp_data  <= 8'h00;
              r_rsp_err   <= ErrBadOp;
            end
          end
        end
        StSend: begin
          if (w_tx_hs) begin
            r_state     <= StEcho;
            r_tx_tvalid <= 1'b0;
            r_rx_tready <= 1'b1;
            r_cnt       <= '0;
          end else if (w_to) begin
            r_state     <= StDone;
            r_tx_tvalid <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= 8'h00;
            r_rsp_err   <= ErrTimeout;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StEcho: begin
          if (w_rx_hs) begin
            r_cnt      <= '0;
            r_mismatch <= w_mismatch;
            if (r_idx != 2'd2) begin
              // Keep sending after a bad echo so the remote frame stays aligned.
              r_idx       <= r_idx + 2'd1;
              r_state     <= StSend;
              r_tx_tvalid <= 1'b1;
              r_rx_tready <= 1'b0;
              r_tx_tdata  <= (r_idx == 2'd0) ? r_b1 : r_b2;
            end else if (r_reply) begin
              r_state <= StReply;
            end else begin
              r_state     <= StDone;
              r_rx_tready <= 1'b0;
              r_rsp_valid <= 1'b1;
              r_rsp_data  <= 8'h00;
              r_rsp_err   <= w_mismatch ? ErrMismatch : ErrOk;
            end
          end else if (w_to) begin
            r_state     <= StDone;
            r_rx_tready <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= 8'h00;
            r_rsp_err   <= ErrTimeout;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StReply: begin
          if (w_rx_hs) begin
            r_state     <= StDone;
            r_rx_tready <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= i_rx_tdata;
            r_rsp_err   <= r_mismatch ? ErrMismatch : ErrOk;
          end else if (w_to) begin
            r_state     <= StDone;
            r_rx_tready <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= 8'h00;
            r_rsp_err   <= ErrTimeout;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StDone: begin
          r_state     <= StIdle;
          r_rx_tready <= 1'b1;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_cmd_ready = (r_state == StIdle);
  assign o_tx_tdata  = r_tx_tdata;
  assign o_tx_tvalid = r_tx_tvalid;
  assign o_rx_tready = r_rx_tready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_data  = r_rsp_data;
  assign o_rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_fmq_cmd_tx.sv
// Randomized bench for fmq_cmd_tx: a UART responder drives echoes/replies and a frame/latency
// model predicts every transmitted byte and response.
module tb_fmq_cmd_tx;

  localparam int unsigned TO = 24;

`ifdef FMQ_CMD_ECHO_CHECK_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_cmd_valid = 1'b0;
  logic        o_cmd_ready;
  logic [2:0]  i_cmd_op = 3'd0;
  logic [18:0] i_cmd_arg = 19'd0;
  logic [7:0]  o_tx_tdata;
  logic        o_tx_tvalid;
  logic        i_tx_tready = 1'b0;
  logic [7:0]  i_rx_tdata = 8'h00;
  logic        i_rx_tvalid = 1'b0;
  logic        o_rx_tready;
  logic        o_rsp_valid;
  logic [7:0]  o_rsp_data;
  logic [1:0]  o_rsp_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fmq_cmd_tx #(
    .TIMEOUT  (TO),
    .TO_WIDTH (8)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .i_cmd_valid (i_cmd_valid),
    .o_cmd_ready (o_cmd_ready),
    .i_cmd_op    (i_cmd_op),
    .i_cmd_arg   (i_cmd_arg),
    .o_tx_tdata  (o_tx_tdata),
    .o_tx_tvalid (o_tx_tvalid),
    .i_tx_tready (i_tx_tready),
    .i_rx_tdata  (i_rx_tdata),
    .i_rx_tvalid (i_rx_tvalid),
    .o_rx_tready (o_rx_tready),
    .o_rsp_valid (o_rsp_valid),
    .o_rsp_data  (o_rsp_data),
    .o_rsp_err   (o_rsp_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Frame model: byte0 = 128 + 32*op2 + f, byte1 = g, byte2 = h.
  function automatic logic [23:0] model_frame(input int op, input int arg);
    int op2, f, g, h, b0;
    op2 = 3; f = 0; g = 0; h = 0;
    case (op)
      0, 1: begin
        op2 = op;
        f   = arg / 16384;
        g   = (arg / 128) % 128;
        h   = arg % 128;
      end
      2: op2 = 2;
      3: begin
        g = (arg % 512) / 128;
        h = arg % 128;
      end
      4: f = 16;
      5: f = 8;
      default: ;
    endcase
    b0 = 128 + op2 * 32 + f;
    return {8'(b0), 8'(g), 8'(h)};
  endfunction

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_cmd_ready"}, o_cmd_ready, 1);
    check_eq({tag, "_tx_tvalid"}, o_tx_tvalid, 0);
    check_eq({tag, "_tx_tdata"}, o_tx_tdata, 8'h00);
    check_eq({tag, "_rx_tready"}, o_rx_tready, 1);
    check_eq({tag, "_rsp_valid"}, o_rsp_valid, 0);
    check_eq({tag, "_rsp_data"}, o_rsp_data, 8'h00);
    check_eq({tag, "_rsp_err"}, o_rsp_err, 2'd0);
  endtask

  task automatic accept_cmd(input int op, input int arg);
    int waited;
    waited = 0;
    while (!o_cmd_ready && waited < 50) begin
      tick();
      waited++;
    end
    check_eq("cmd_ready_wait", o_cmd_ready, 1);
    i_cmd_valid = 1'b1;
    i_cmd_op    = op[2:0];
    i_cmd_arg   = arg[18:0];
    tick();
    i_cmd_valid = 1'b0;
    i_cmd_op    = 3'($urandom);
    i_cmd_arg   = 19'($urandom);
  endtask

  // silent_at: 0..2 = responder never takes byte i, 3 = no reply, other = fully responsive.
  task automatic run_txn(input int op, input int arg, input int corrupt_idx, input int silent_at,
                         input logic [7:0] reply);
    logic [23:0] fr;
    logic [7:0]  exp_b;
    bit          timed_out;
    bit          has_reply;
    bit          early;
    int          exp_err;
    int          exp_data;
    fr        = model_frame(op, arg);
    has_reply = (op == 2) || (op == 5);
    timed_out = 1'b0;
    accept_cmd(op, arg);
    if (op > 5) begin
      check_eq("badop_tx_tvalid", o_tx_tvalid, 0);
      check_eq("badop_rsp_valid", o_rsp_valid, 1);
      check_eq("badop_rsp_err", o_rsp_err, 3);
      check_eq("badop_rsp_data", o_rsp_data, 8'h00);
      tick();
      check_eq("badop_tx_tvalid2", o_tx_tvalid, 0);
      check_eq("badop_cmd_ready", o_cmd_ready, 1);
      check_eq("badop_rsp_pulse", o_rsp_valid, 0);
      return;
    end
    for (int i = 0; i < 3 && !timed_out; i++) begin
      exp_b = fr[23 - 8 * i -: 8];
      check_eq("tx_tvalid_rise", o_tx_tvalid, 1);
      check_eq("rx_tready_send", o_rx_tready, 0);
      if (silent_at == i) begin
        timed_out = 1'b1;
      end else begin
        repeat ($urandom_range(0, 2)) begin
          tick();
          check_eq("tx_hold_valid", o_tx_tvalid, 1);
          check_eq("tx_hold_data", o_tx_tdata, exp_b);
        end
        check_eq("tx_tdata", o_tx_tdata, exp_b);
        i_tx_tready = 1'b1;
        tick();
        i_tx_tready = 1'b0;
        check_eq("tx_tvalid_drop", o_tx_tvalid, 0);
        repeat ($urandom_range(0, 2)) tick();
        check_eq("rx_tready_echo", o_rx_tready, 1);
        i_rx_tvalid = 1'b1;
        i_rx_tdata  = (i == corrupt_idx) ? (exp_b ^ 8'h5A) : exp_b;
        tick();
        i_rx_tvalid = 1'b0;
      end
    end
    if (!timed_out && has_reply) begin
      if (silent_at == 3) begin
        timed_out = 1'b1;
      end else begin
        repeat ($urandom_range(0, 2)) tick();
        check_eq("rx_tready_reply", o_rx_tready, 1);
        i_rx_tvalid = 1'b1;
        i_rx_tdata  = reply;
        tick();
        i_rx_tvalid = 1'b0;
      end
    end
    if (timed_out) begin
      early = 1'b0;
      repeat (TO - 1) begin
        tick();
        early |= o_rsp_valid;
      end
      check_eq("timeout_early", early, 0);
      tick();
      exp_err  = 1;
      exp_data = 0;
    end else begin
      exp_err  = (ChkEn && corrupt_idx >= 0 && corrupt_idx < 3) ? 2 : 0;
      exp_data = has_reply ? int'(reply) : 0;
    end
    check_eq("rsp_valid", o_rsp_valid, 1);
    check_eq("rsp_err", o_rsp_err, exp_err);
    check_eq("rsp_data", o_rsp_data, exp_data);
    check_eq("done_tx_tvalid", o_tx_tvalid, 0);
    check_eq("done_rx_tready", o_rx_tready, 0);
    tick();
    check_eq("next_cmd_ready", o_cmd_ready, 1);
    check_eq("rsp_pulse_end", o_rsp_valid, 0);
    check_eq("rsp_err_hold", o_rsp_err, exp_err);
    check_eq("rsp_data_hold", o_rsp_data, exp_data);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int op, arg, cor, sil;
    #2;
    rst = 1'b0;
    tick();
    tick();
    check_reset_vals("reset");
    rst = 1'b1;
    tick();

    // Stray byte in idle is swallowed without a response.
    i_rx_tvalid = 1'b1;
    i_rx_tdata  = 8'h77;
    tick();
    i_rx_tvalid = 1'b0;
    check_eq("stray_rx_tready", o_rx_tready, 1);
    check_eq("stray_rsp_valid", o_rsp_valid, 0);
    check_eq("stray_cmd_ready", o_cmd_ready, 1);

    run_txn(0, (32'h55 << 12) | (1 << 11) | 32'h3A5, -1, 99, 8'h00);
    run_txn(5, 0, -1, 99, 8'h04);
    run_txn(1, 32'h7FFFF, 1, 99, 8'h00);
    run_txn(2, 0, -1, 2, 8'h00);
    run_txn(7, 32'h12345, -1, 99, 8'h00);
    run_txn(6, 0, -1, 99, 8'h00);

    // Reset while byte 1 of a SET_DAC frame is stalled.
    accept_cmd(3, 32'h1AB);
    i_tx_tready = 1'b1;
    tick();
    i_tx_tready = 1'b0;
    i_rx_tvalid = 1'b1;
    i_rx_tdata  = 8'hE0;
    tick();
    i_rx_tvalid = 1'b0;
    tick();
    check_eq("pre_rst_tx_tvalid", o_tx_tvalid, 1);
    #2;
    rst = 1'b0;
    #1;
    check_reset_vals("async_rst");
    tick();
    rst = 1'b1;
    tick();
    run_txn(4, 0, -1, 99, 8'h00);

    for (int t = 0; t < 40; t++) begin
      op  = $urandom_range(0, 7);
      arg = int'($urandom & 32'h7FFFF);
      cor = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : -1;
      sil = 99;
      if ($urandom_range(0, 5) == 0) begin
        sil = ((op == 2) || (op == 5)) ? $urandom_range(0, 3) : $urandom_range(0, 2);
      end
      run_txn(op, arg, cor, sil, 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
